// File: rtl/vga_sync_if.sv
// ---------------------------------------------------------------------------
// vga_sync_if
//   Signal bundle leaving the VGA timing generator. The generator drives it
//   through the master modport. The figure, text and RGB-mux generators, and
//   the monitor pins, observe it through the slave modport.
//
//   hsync      : horizontal sync, active-low, registered
//   vsync      : vertical sync, active-low, registered
//   video_on   : current pixel lies in the visible region
//   p_tick     : one-clk pixel enable; consumers sample coordinates on it
//   frame_tick : one-clk pulse on the last pixel of a frame
//   pixel_x    : current horizontal count, 0..H_TOT-1
//   pixel_y    : current vertical count, 0..V_TOT-1
// ---------------------------------------------------------------------------
interface vga_sync_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       frame_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;

    modport master (
        output hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
    );

    modport slave (
        input hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
    );
endinterface

// File: rtl/vga_sync.sv
// ---------------------------------------------------------------------------
// vga_sync
//   Raster timing generator for the VGA display path. It is set up for
//   640x480 @ 60 Hz by default.
//   - Divides clk down to a pixel-rate enable (p_tick, once per CLK_DIV clks).
//   - Runs the horizontal (h) and vertical (v) counters.
//   - Produces the active-low sync pulses and the visible-region flag.
//
//   Ports
//     clk   : system clock
//     reset : asynchronous, active-high; returns every output to the (0,0)
//             state at once
//     vga   : vga_sync_if.master. Carries hsync, vsync, video_on, p_tick,
//             frame_tick, pixel_x and pixel_y.
//
//   Constraints on the parameters:
//     - CLK_DIV >= 2.
//     - H_TOT <= 1024 and V_TOT <= 1024, because the counters are 10 bits.
//     - H_DISP+H_FP > 0 and V_DISP+V_FP > 0. This keeps (0,0) outside the
//       sync window, so the reset value of the sync registers is 1.
// ---------------------------------------------------------------------------
module vga_sync #(
    parameter int CLK_DIV = 4,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master vga
);

    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [9:0] HS_FIRST = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;

    logic p_tick;
    logic h_last;
    logic v_last;

    // Next-state logic. The divider wraps explicitly on p_tick, so CLK_DIV
    // values that are not a power of two still give an exact period.
    always_comb begin
        p_tick = (div_q == DIV_LAST);
        h_last = (h_q == H_LAST);
        v_last = (v_q == V_LAST);

        div_d  = p_tick ? '0 : div_q + DIV_ONE;
        h_d    = h_q;
        v_d    = v_q;

        if (p_tick) begin
            h_d = h_last ? '0 : h_q + 10'd1;
            if (h_last) begin
                v_d = v_last ? '0 : v_q + 10'd1;
            end
        end

        // The sync windows are decoded from the next-state counts. The
        // registered pulse therefore changes on the same edge as the
        // coordinate it belongs to, so there is no skew against
        // pixel_x/pixel_y.
        hsync_d = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
        vsync_d = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga.pixel_x    = h_q;
    assign vga.pixel_y    = v_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.p_tick     = p_tick;
    // (0,0) is visible, so video_on reads 1 while reset is held.
    assign vga.video_on   = (h_q < H_VIS) && (v_q < V_VIS);
    // frame_tick is decoded from the registers. It is high in the single
    // clk that advances (H_TOT-1, V_TOT-1) to (0,0).
    assign vga.frame_tick = p_tick && h_last && v_last;

endmodule

// File: tb/tb_vga_sync.sv
// ---------------------------------------------------------------------------
// tb_vga_sync
//   Directed bench for vga_sync. It uses three instances:
//     A: default 640x480 timing with CLK_DIV = 4
//     B: small raster with CLK_DIV = 2 (H 8/2/3/2 -> 15, V 6/2/2/2 -> 12).
//        It covers full frames, frame wrap and the mid-frame reset, all in
//        a short run.
//     C: default raster timing with CLK_DIV = 2
//   Expected values come from elapsed-clock arithmetic after reset release:
//     after edge n, (n+1) clks have elapsed
//     pixel = (n+1)/CLK_DIV
//     h = pixel % H_TOT
//     v = (pixel / H_TOT) % V_TOT
//   Window membership is then tested directly against the porch parameters.
// ---------------------------------------------------------------------------
module tb_vga_sync;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_sync_if if_a ();
    vga_sync_if if_b ();
    vga_sync_if if_c ();

    vga_sync dut_a (.clk(clk), .reset(rst_a), .vga(if_a));

    vga_sync #(
        .CLK_DIV(2),
        .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISP(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_b (.clk(clk), .reset(rst_b), .vga(if_b));

    vga_sync #(.CLK_DIV(2)) dut_c (.clk(clk), .reset(rst_c), .vga(if_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic rst_check(input string tag, input logic [9:0] px, input logic [9:0] py,
                             input logic hs, input logic vs, input logic vo,
                             input logic pt, input logic ft);
        chk({tag, ".pixel_x"},    32'(px), 32'd0);
        chk({tag, ".pixel_y"},    32'(py), 32'd0);
        chk({tag, ".hsync"},      32'(hs), 32'd1);
        chk({tag, ".vsync"},      32'(vs), 32'd1);
        chk({tag, ".video_on"},   32'(vo), 32'd1);
        chk({tag, ".p_tick"},     32'(pt), 32'd0);
        chk({tag, ".frame_tick"}, 32'(ft), 32'd0);
    endtask

    // n = index of the clk edge after reset release (0 = first edge).
    task automatic check_point(input string tag, input int n, input int cd,
                               input int hd, input int hfp, input int hsw, input int hbp,
                               input int vd, input int vfp, input int vsw, input int vbp,
                               input logic [9:0] px, input logic [9:0] py,
                               input logic hs, input logic vs, input logic vo,
                               input logic pt, input logic ft);
        int htot, vtot, pix, eh, ev;
        logic ept, ehs, evs, evo, eft;
        htot = hd + hfp + hsw + hbp;
        vtot = vd + vfp + vsw + vbp;
        pix  = (n + 1) / cd;
        eh   = pix % htot;
        ev   = (pix / htot) % vtot;
        ept  = (((n + 1) % cd) == (cd - 1));
        ehs  = !((eh >= hd + hfp) && (eh <= hd + hfp + hsw - 1));
        evs  = !((ev >= vd + vfp) && (ev <= vd + vfp + vsw - 1));
        evo  = (eh < hd) && (ev < vd);
        eft  = ept && (eh == htot - 1) && (ev == vtot - 1);
        chk({tag, ".pixel_x"},    32'(px), 32'(eh));
        chk({tag, ".pixel_y"},    32'(py), 32'(ev));
        chk({tag, ".p_tick"},     32'(pt), 32'(ept));
        chk({tag, ".hsync"},      32'(hs), 32'(ehs));
        chk({tag, ".vsync"},      32'(vs), 32'(evs));
        chk({tag, ".video_on"},   32'(vo), 32'(evo));
        chk({tag, ".frame_tick"}, 32'(ft), 32'(eft));
    endtask

    initial begin
        int  hs_low, first_hs_x, vo_off_x, first_pt, first_x1, y1_edge;
        int  ft_count, ft_first, ft_second, vs_low_ticks, both_low;
        bit  found;

        // ---------------- reset hold ----------------
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_check("A.reset", if_a.pixel_x, if_a.pixel_y, if_a.hsync, if_a.vsync,
                  if_a.video_on, if_a.p_tick, if_a.frame_tick);
        rst_check("B.reset", if_b.pixel_x, if_b.pixel_y, if_b.hsync, if_b.vsync,
                  if_b.video_on, if_b.p_tick, if_b.frame_tick);
        rst_check("C.reset", if_c.pixel_x, if_c.pixel_y, if_c.hsync, if_c.vsync,
                  if_c.video_on, if_c.p_tick, if_c.frame_tick);

        // ---------------- A: one line plus a few pixels ----------------
        rst_a      = 1'b0;
        hs_low     = 0;
        first_hs_x = -1;
        vo_off_x   = -1;
        first_pt   = -1;
        first_x1   = -1;
        y1_edge    = -1;
        for (int n = 0; n < 3300; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_point("A", n, 4, 640, 16, 96, 48, 480, 10, 2, 33,
                        if_a.pixel_x, if_a.pixel_y, if_a.hsync, if_a.vsync,
                        if_a.video_on, if_a.p_tick, if_a.frame_tick);
            if (n < 3200 && !if_a.hsync) begin
                hs_low++;
                if (first_hs_x < 0) first_hs_x = int'(if_a.pixel_x);
            end
            if (vo_off_x < 0 && !if_a.video_on) vo_off_x = int'(if_a.pixel_x);
            if (first_pt < 0 && if_a.p_tick) first_pt = n;
            if (first_x1 < 0 && if_a.pixel_x == 10'd1) first_x1 = n;
            if (y1_edge < 0 && if_a.pixel_y == 10'd1) y1_edge = n;
        end
        // p_tick is sampled high just before edge index 3, and the x=1
        // count appears right after that edge.
        chk("A.first_p_tick_edge", 32'(first_pt),   32'd2);
        chk("A.first_x1_edge",     32'(first_x1),   32'd3);
        chk("A.hsync_low_clks",    32'(hs_low),     32'd384);
        chk("A.hsync_first_x",     32'(first_hs_x), 32'd656);
        chk("A.video_off_x",       32'(vo_off_x),   32'd640);
        chk("A.line_wrap_edge",    32'(y1_edge),    32'd3199);

        // ---------------- C: CLK_DIV = 2, default raster ----------------
        rst_c      = 1'b0;
        hs_low     = 0;
        first_hs_x = -1;
        y1_edge    = -1;
        for (int n = 0; n < 1700; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_point("C", n, 2, 640, 16, 96, 48, 480, 10, 2, 33,
                        if_c.pixel_x, if_c.pixel_y, if_c.hsync, if_c.vsync,
                        if_c.video_on, if_c.p_tick, if_c.frame_tick);
            if (n < 1600 && !if_c.hsync) begin
                hs_low++;
                if (first_hs_x < 0) first_hs_x = int'(if_c.pixel_x);
            end
            if (y1_edge < 0 && if_c.pixel_y == 10'd1) y1_edge = n;
        end
        chk("C.hsync_low_clks", 32'(hs_low),     32'd192);
        chk("C.hsync_first_x",  32'(first_hs_x), 32'd656);
        chk("C.line_wrap_edge", 32'(y1_edge),    32'd1599);

        // ---------------- B: two frames of the small raster ----------------
        rst_b        = 1'b0;
        ft_count     = 0;
        ft_first     = -1;
        ft_second    = -1;
        vs_low_ticks = 0;
        both_low     = 0;
        for (int n = 0; n < 760; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_point("B", n, 2, 8, 2, 3, 2, 6, 2, 2, 2,
                        if_b.pixel_x, if_b.pixel_y, if_b.hsync, if_b.vsync,
                        if_b.video_on, if_b.p_tick, if_b.frame_tick);
            if (if_b.frame_tick) begin
                ft_count++;
                if (ft_first < 0) ft_first = n;
                else if (ft_second < 0) ft_second = n;
            end
            if (n < 360 && !if_b.vsync && if_b.p_tick) vs_low_ticks++;
            if (n < 360 && !if_b.vsync && !if_b.hsync) both_low++;
        end
        chk("B.frame_tick_count", 32'(ft_count),             32'd2);
        chk("B.frame_tick_first", 32'(ft_first),             32'd358);
        chk("B.frame_period",     32'(ft_second - ft_first), 32'd360);
        chk("B.vsync_low_pixels", 32'(vs_low_ticks),         32'd30);
        chk("B.hsync_in_vsync",   32'(both_low),             32'd12);

        // ---------------- B: asynchronous reset mid-frame ----------------
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (if_b.pixel_x == 10'd12 && if_b.pixel_y == 10'd9) found = 1'b1;
        end
        chk("B.reached_12_9",   32'(found),      32'd1);
        chk("B.pre_rst.hsync",  32'(if_b.hsync), 32'd0);
        chk("B.pre_rst.vsync",  32'(if_b.vsync), 32'd0);
        #2 rst_b = 1'b1;
        #1;
        rst_check("B.async_rst", if_b.pixel_x, if_b.pixel_y, if_b.hsync, if_b.vsync,
                  if_b.video_on, if_b.p_tick, if_b.frame_tick);
        @(negedge clk);
        rst_b = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_point("B.restart", n, 2, 8, 2, 3, 2, 6, 2, 2, 2,
                        if_b.pixel_x, if_b.pixel_y, if_b.hsync, if_b.vsync,
                        if_b.video_on, if_b.p_tick, if_b.frame_tick);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
